// File: rtl/demux_1x4_sched.sv
// Round-robin burst scheduler that owns the select of a combinational 1x4 demux.
// Grants one enabled channel at a time for up to BURST words; a grant ends early on disable or stall timeout.
module demux_1x4_sched #(
  parameter int W     = 8,
  parameter int BURST = 4,
  parameter int TMO   = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_en_mask,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  input  logic [3:0]   i_out_ready,
  output logic [3:0]   o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic [1:0]   o_sel,
  output logic         o_busy,
  output logic         o_burst_done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(BURST - 1);
  localparam logic [7:0] STALL_LAST = 8'(TMO - 1);
  localparam logic       TMO_ON     = (TMO != 0) ? 1'b1 : 1'b0;

  state_t     r_state;
  logic [1:0] r_last;
  logic [1:0] r_sel;
  logic [7:0] r_cnt;
  logic [7:0] r_stall;
  logic       r_busy;
  logic       r_burst_done;

  state_t     w_state_nxt;
  logic [1:0] w_last_nxt;
  logic [1:0] w_sel_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_stall_nxt;
  logic       w_release;
  logic       w_is_grant;
  logic       w_en_sel;
  logic       w_xfer;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_hit;

  assign w_is_grant   = (r_state == S_GRANT);
  assign w_en_sel     = i_en_mask[r_sel];
  assign o_in_ready   = w_is_grant & i_out_ready[r_sel] & w_en_sel;
  assign w_xfer       = i_in_valid & o_in_ready;
  assign o_out_valid  = (w_is_grant & i_in_valid & w_en_sel) ? (4'b0001 << r_sel) : 4'b0000;
  assign o_out_data   = w_is_grant ? i_in_data : {W{1'b0}};
  assign o_sel        = r_sel;
  assign o_busy       = r_busy;
  assign o_burst_done = r_burst_done;

  // Round-robin pick: first enabled channel after the last grant, wrapping back to it last.
  always_comb begin
    w_pick  = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    w_hit   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx   = r_last + 2'(k);
      w_hit   = ~w_found & i_en_mask[w_idx];
      w_pick  = w_hit ? w_idx : w_pick;
      w_found = w_found | w_hit;
    end
  end

  // Next-state and burst bookkeeping for the IDLE/GRANT sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_stall_nxt = r_stall;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = 8'd0;
          w_stall_nxt = 8'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!w_en_sel) begin
          w_release = 1'b1;
        end else if (w_xfer) begin
          w_cnt_nxt   = r_cnt + 8'd1;
          w_stall_nxt = 8'd0;
          w_release   = (r_cnt == CNT_LAST);
        end else begin
          // Saturate so a disabled timeout can never wrap the stall count.
          w_stall_nxt = (r_stall == 8'hFF) ? r_stall : (r_stall + 8'd1);
          w_release   = TMO_ON & (r_stall == STALL_LAST);
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_sel;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aims the first grant at channel 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 2'd3;
      r_sel        <= 2'd0;
      r_cnt        <= 8'd0;
      r_stall      <= 8'd0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_sel        <= w_sel_nxt;
      r_cnt        <= w_cnt_nxt;
      r_stall      <= w_stall_nxt;
      r_busy       <= (w_state_nxt == S_GRANT);
      r_burst_done <= w_release;
    end
  end

endmodule

// File: tb/tb_demux_1x4_sched.sv
// Randomised bench for demux_1x4_sched against a cycle-level behavioural model of the grant rules.
// Scenario tasks add targeted checks on grant order, timeout length and reset behaviour.
module tb_demux_1x4_sched;
  localparam int W     = 8;
  localparam int BURST = 4;
  localparam int TMO   = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   en_mask;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [3:0]   out_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   sel;
  logic         busy;
  logic         burst_done;

  always #5 clk = ~clk;

  demux_1x4_sched #(.W(W), .BURST(BURST), .TMO(TMO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en_mask    (en_mask),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .i_out_ready  (out_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_sel        (sel),
    .o_busy       (busy),
    .o_burst_done (burst_done)
  );

  logic [16:0] obs;
  assign obs = {in_ready, out_valid, out_data, sel, busy, burst_done};

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: who holds the grant, how many words moved, how long it has stalled.
  bit m_grant;
  int m_sel;
  int m_last;
  int m_words;
  int m_stall;
  bit m_done;

  function automatic void model_reset();
    m_grant = 1'b0;
    m_sel   = 0;
    m_last  = 3;
    m_words = 0;
    m_stall = 0;
    m_done  = 1'b0;
  endfunction

  function automatic logic [16:0] model_out();
    logic         ir;
    logic [3:0]   ov;
    logic [W-1:0] od;
    ir = m_grant && out_ready[m_sel] && en_mask[m_sel];
    ov = (m_grant && in_valid && en_mask[m_sel]) ? (4'b0001 << m_sel) : 4'b0000;
    od = m_grant ? in_data : '0;
    return {ir, ov, od, m_sel[1:0], m_grant, m_done};
  endfunction

  function automatic int code_of(input int q[$], input int n);
    int c;
    c = 1;
    if (q.size() < n) return -1;
    for (int i = 0; i < n; i++) c = c * 4 + q[i];
    return c;
  endfunction

  task automatic tick();
    bit rel;
    bit found;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!m_grant) begin
      m_done = 1'b0;
      if (en_mask != 4'b0000) begin
        found = 1'b0;
        for (int j = 1; j <= 4; j++) begin
          if (!found && en_mask[(m_last + j) % 4]) begin
            m_sel = (m_last + j) % 4;
            found = 1'b1;
          end
        end
        m_grant = 1'b1;
        m_words = 0;
        m_stall = 0;
      end
    end else begin
      rel = 1'b0;
      if (!en_mask[m_sel]) begin
        rel = 1'b1;
      end else if (in_valid && out_ready[m_sel]) begin
        m_words++;
        m_stall = 0;
        rel = (m_words == BURST);
      end else begin
        m_stall++;
        rel = (TMO != 0) && (m_stall == TMO);
      end
      m_done = rel;
      if (rel) begin
        m_grant = 1'b0;
        m_last  = m_sel;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n     = 1'b0;
    en_mask   = 4'hF;
    in_valid  = 1'b1;
    out_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      in_data = W'($urandom);
      if (c == 3) rst_n = 1'b1;
      #1;
      vectors++;
      if (obs !== 17'd0) begin
        $display("FAIL reset_outputs c=%0d got=%h exp=%h", c, obs, 17'd0);
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int done_c[$];
    int exp_o[$] = '{0, 1, 2, 3, 0};
    int dc;
    bit prev_busy = 1'b0;
    apply_reset();
    en_mask = 4'hF; in_valid = 1'b1; out_ready = 4'hF;
    for (int c = 0; c < 26; c++) begin
      in_data = W'($urandom);
      #1;
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL round_robin c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      if (busy && !prev_busy) order.push_back(int'(sel));
      if (burst_done) done_c.push_back(c);
      prev_busy = busy;
      tick();
    end
    vectors++;
    if (code_of(order, 5) !== code_of(exp_o, 5)) begin
      $display("FAIL rr_order got=%0d exp=%0d", code_of(order, 5), code_of(exp_o, 5));
      miscompares++;
    end
    dc = (done_c.size() >= 3) ? done_c[0] * 10000 + done_c[1] * 100 + done_c[2] : -1;
    vectors++;
    if (dc !== 51015) begin
      $display("FAIL rr_done_cycles got=%0d exp=%0d", dc, 51015);
      miscompares++;
    end
  endtask

  task automatic test_sparse_mask();
    int order[$];
    int exp_o[$] = '{0, 2, 0, 2};
    logic [3:0] seen = 4'b0000;
    bit prev_busy = 1'b0;
    apply_reset();
    en_mask = 4'b0101; out_ready = 4'hF;
    for (int c = 0; c < 60; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      #1;
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL sparse c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      seen = seen | out_valid;
      if (busy && !prev_busy) order.push_back(int'(sel));
      prev_busy = busy;
      tick();
    end
    vectors++;
    if ((seen & 4'b1010) !== 4'b0000) begin
      $display("FAIL sparse_disabled_valid got=%b exp=%b", seen & 4'b1010, 4'b0000);
      miscompares++;
    end
    vectors++;
    if (code_of(order, 4) !== code_of(exp_o, 4)) begin
      $display("FAIL sparse_order got=%0d exp=%0d", code_of(order, 4), code_of(exp_o, 4));
      miscompares++;
    end
  endtask

  task automatic test_stall_timeout();
    int order[$];
    int exp_o[$] = '{0, 1};
    int stalls = 0;
    int done_after_stall = 0;
    bit dropped = 1'b0;
    bit restored = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_busy = 1'b0;
    apply_reset();
    en_mask = 4'hF; in_valid = 1'b1; out_ready = 4'hF;
    for (int c = 0; c < 40; c++) begin
      if (!dropped && m_grant && m_sel == 0 && m_words == 2) begin
        out_ready = 4'b1110;
        dropped = 1'b1;
      end else if (dropped && !restored && !m_grant) begin
        out_ready = 4'hF;
        restored = 1'b1;
      end
      in_data = W'($urandom);
      #1;
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL stall c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      if (burst_done && prev_stall) done_after_stall++;
      prev_stall = busy && sel == 2'd0 && !in_ready;
      if (prev_stall) stalls++;
      if (busy && !prev_busy) order.push_back(int'(sel));
      prev_busy = busy;
      tick();
    end
    vectors++;
    if (stalls !== TMO) begin
      $display("FAIL stall_length got=%0d exp=%0d", stalls, TMO);
      miscompares++;
    end
    vectors++;
    if (done_after_stall !== 1) begin
      $display("FAIL stall_done_pulse got=%0d exp=%0d", done_after_stall, 1);
      miscompares++;
    end
    vectors++;
    if (code_of(order, 2) !== code_of(exp_o, 2)) begin
      $display("FAIL stall_next_grant got=%0d exp=%0d", code_of(order, 2), code_of(exp_o, 2));
      miscompares++;
    end
  endtask

  task automatic test_disable();
    int order[$];
    int exp_o[$] = '{0, 1, 2, 3, 0, 2};
    int dis_c = -10;
    bit prev_busy = 1'b0;
    apply_reset();
    en_mask = 4'hF; in_valid = 1'b1; out_ready = 4'hF;
    for (int c = 0; c < 40; c++) begin
      if (dis_c < 0 && m_grant && m_sel == 1 && m_words == 2) begin
        en_mask = 4'b1101;
        dis_c = c;
      end
      in_data = W'($urandom);
      #1;
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL disable c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      if (c == dis_c) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          $display("FAIL disable_ready got=%b exp=%b", in_ready, 1'b0);
          miscompares++;
        end
      end
      if (c == dis_c + 1) begin
        vectors++;
        if (busy !== 1'b0) begin
          $display("FAIL disable_idle got=%b exp=%b", busy, 1'b0);
          miscompares++;
        end
      end
      if (busy && !prev_busy) order.push_back(int'(sel));
      prev_busy = busy;
      tick();
    end
    en_mask = 4'hF;
    vectors++;
    if (code_of(order, 6) !== code_of(exp_o, 6)) begin
      $display("FAIL disable_order got=%0d exp=%0d", code_of(order, 6), code_of(exp_o, 6));
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    int post[$];
    int exp_o[$] = '{0};
    bit hit = 1'b0;
    bit prev_busy = 1'b0;
    apply_reset();
    en_mask = 4'hF; in_valid = 1'b1; out_ready = 4'hF;
    for (int c = 0; c < 45; c++) begin
      in_data = W'($urandom);
      if (!hit && m_grant && m_sel == 2 && m_words >= 1) begin
        hit = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 17'd0) begin
          $display("FAIL async_reset_outputs got=%h exp=%h", obs, 17'd0);
          miscompares++;
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        prev_busy = 1'b0;
      end else begin
        #1;
        vectors++;
        if (obs !== model_out()) begin
          $display("FAIL async_reset c=%0d got=%h exp=%h", c, obs, model_out());
          miscompares++;
        end
        if (hit && busy && !prev_busy) post.push_back(int'(sel));
        prev_busy = busy;
        tick();
      end
    end
    vectors++;
    if (code_of(post, 1) !== code_of(exp_o, 1)) begin
      $display("FAIL async_reset_first_grant got=%0d exp=%0d hit=%0d", code_of(post, 1), code_of(exp_o, 1), hit);
      miscompares++;
    end
  endtask

  task automatic test_no_enables();
    apply_reset();
    en_mask = 4'b0000; in_valid = 1'b1; out_ready = 4'hF;
    for (int c = 0; c < 20; c++) begin
      in_data = W'($urandom_range(1, 255));
      #1;
      vectors++;
      if (obs !== 17'd0) begin
        $display("FAIL no_enables c=%0d got=%h exp=%h", c, obs, 17'd0);
        miscompares++;
      end
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL no_enables_model c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    en_mask = 4'hF;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) en_mask = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      #1;
      vectors++;
      if (obs !== model_out()) begin
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, model_out());
        miscompares++;
      end
      tick();
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en_mask   = 4'b0000;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 4'b0000;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_sparse_mask();
    test_stall_timeout();
    test_disable();
    test_async_reset();
    test_no_enables();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
